memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Multi-cycle arbiter that shares the single RAM port between the instruction and data requests of `CPUS` cores. It sits between the per-core caches/request units and the RAM model. It grants one requester at a time, holds the grant until RAM reports `ACCESS`, and then returns the load word and drops that requester's wait. Data requests take priority over instruction requests, and cores are served round-robin.

## Interface
Parameters:
- `CPUS`, default 2: number of cores sharing the RAM; must be ≥1.

Ports. Arrays are indexed by core; `word_t` is 32 bits.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `iREN` in [CPUS]: instruction read request.
- `iaddr` in [CPUS]×32: instruction address.
- `dREN` in [CPUS]: data read request.
- `dWEN` in [CPUS]: data write request.
- `daddr` in [CPUS]×32: data address.
- `dstore` in [CPUS]×32: data write word.
- `iwait` out [CPUS]: high unless this cycle completes that core's instruction access.
- `dwait` out [CPUS]: high unless this cycle completes that core's data access.
- `iload` out [CPUS]×32: instruction word; valid when `iwait` is low.
- `dload` out [CPUS]×32: data word; valid when `dwait` is low.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in `ramstate_t`: one of FREE, BUSY, ACCESS, ERROR.

## Operation
- The FSM has two states, IDLE and GRANT. Registers: `state`, `gcore` (log2 CPUS bits), `gdata` (1 = data grant), and `rr` (round-robin pointer).
- **IDLE.** No RAM strobes; all waits are high.
  - If any `dREN|dWEN` is asserted, grant the first requesting core found scanning from `rr` upward with wrap. Latch `gdata=1`.
  - Else if any `iREN` is asserted, grant the same way with `gdata=0`.
  - Else stay in IDLE.
- **GRANT.** RAM signals are driven combinationally from the granted core's current inputs:
  - data grant: `ramaddr=daddr`, `ramstore=dstore`, `ramWEN=dWEN`, `ramREN=dREN&~dWEN`;
  - instruction grant: `ramaddr=iaddr`, `ramREN=1`, `ramWEN=0`.
- **Completion.** In GRANT with `ramstate==ACCESS`:
  - drive the granted wait low for exactly that cycle;
  - route `ramload` to the granted `iload`/`dload`;
  - set `rr <= gcore+1` (mod CPUS) and go to IDLE.
- **Not ready.** `ramstate` FREE, BUSY or ERROR all mean not complete: the grant is held, the wait stays high and the strobes stay asserted.
- **Abort.** If the granted request line drops while in GRANT (`dREN|dWEN` for data, `iREN` for instruction), go to IDLE next edge. There is no completion and `rr` is unchanged.
- **Conflicting strobes.** `dWEN` and `dREN` both high is treated as a write.
- **Load outputs.** All `iload`/`dload` not being completed read as `ramload` (don't-care to consumers). Any ungranted wait is always high.

## Timing
- **Reset.** `state=IDLE`, `rr=0`, `gcore=0`, `gdata=0`.
  - During and after reset: `ramREN=ramWEN=0`, all `iwait`/`dwait`=1.
  - `ramaddr` and `ramstore` are 0 while in IDLE.
- **Reset mid-GRANT.** Strobes drop immediately (asynchronous). No completion is signalled.
- **Latency.**
  - Request visible in IDLE at cycle N → grant registered at edge N+1 → RAM strobes during cycle N+1.
  - Completion occurs in the first cycle ≥N+1 that shows ACCESS.
  - With a zero-wait RAM, completion is in cycle N+1.
- **Back-to-back.** There is one IDLE bubble cycle between consecutive transactions.
- **Simultaneous requests in IDLE.** Data beats instruction on every core. Round-robin applies only within a class.
- **Fairness.** A core whose request is held gets the next grant of its class within CPUS transactions of that class. Instruction requests may starve while data requests persist; this is accepted.

## Structure
- `cpu_types_pkg` provides `word_t` and `ramstate_t`.
- Add to the same package: `arb_state_t` enum {IDLE, GRANT}.
- One sub-module, `rr_picker`: inputs are the request vector [CPUS] and `rr`; outputs are `any` and `idx`. It is combinational.
- Instantiate `rr_picker` twice, once for the data request vector and once for the instruction request vector.
- FSM and output muxing live in `memory_arbiter`.

## Test plan
1. **Reset.** Assert `nRST=0` with all requests high → `ramREN=ramWEN=0`, all waits 1. Release → first grant goes to core0 data.
2. **Single read.** Core0 `dREN`, `daddr=0x100`, RAM with 2-cycle latency and `ramload=0xDEADBEEF` → `ramREN=1`, `ramaddr=0x100` from cycle N+1; `dwait[0]=0` for one cycle at N+3 with `dload[0]=0xDEADBEEF`.
3. **Priority.** Core0 `iREN` and core1 `dWEN` (`dstore=0x55`) asserted together → core1 write first (`ramWEN=1`, `ramstore=0x55`), then the core0 instruction fetch after the bubble.
4. **Round-robin.** Both cores hold `dREN` continuously → completions alternate core0, core1, core0, core1.
5. **Abort.** Core1 `iREN` granted, RAM BUSY, `iREN` dropped → IDLE next cycle, `iwait[1]` never low, `rr` unchanged.
6. **Error and mid-op reset.** `ramstate=ERROR` for 3 cycles then ACCESS → wait held high through ERROR, completes on ACCESS. Pulse `nRST` low during GRANT → strobes low at once, FSM in IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and arbiter FSM types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick; req[N] and start pointer rr in, any (some request) and idx (first requester at or after rr, wrapping) out
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr,
  output logic         any,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    any = |req;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(rr) + i) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port among CPUS cores' i/d requests (data first, round-robin); CLK/nRST, per-core iREN/iaddr/dREN/dWEN/daddr/dstore in, iwait/dwait/iload/dload out, ramREN/ramWEN/ramaddr/ramstore out, ramload/ramstate in
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  iload,
  output logic [CPUS-1:0][31:0]  dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  ramstate_t              ramstate
);
  localparam int CW = CPUS > 1 ? $clog2(CPUS) : 1;
  arb_state_t state, state_n;
  logic [CW-1:0] gcore, gcore_n, rr, rr_n, d_idx, i_idx;
  logic gdata, gdata_n, d_any, i_any, live, done;
  logic [CPUS-1:0] dreq;
  assign dreq = dREN | dWEN;
  rr_picker #(.N(CPUS), .W(CW)) u_dpick (.req(dreq), .rr(rr), .any(d_any), .idx(d_idx));
  rr_picker #(.N(CPUS), .W(CW)) u_ipick (.req(iREN), .rr(rr), .any(i_any), .idx(i_idx));
  assign live = gdata ? dreq[gcore] : iREN[gcore];
  assign done = state == GRANT && live && ramstate == ACCESS;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      gcore <= '0;
      gdata <= 1'b0;
      rr <= '0;
    end else begin
      state <= state_n;
      gcore <= gcore_n;
      gdata <= gdata_n;
      rr <= rr_n;
    end
  always_comb begin
    state_n = state;
    gcore_n = gcore;
    gdata_n = gdata;
    rr_n = rr;
    if (state == IDLE) begin
      if (d_any || i_any) begin
        state_n = GRANT;
        gdata_n = d_any;
        gcore_n = d_any ? d_idx : i_idx;
      end
    end else if (done || !live) begin
      state_n = IDLE;
      if (done) rr_n = gcore == CW'(CPUS - 1) ? '0 : gcore + 1'b1;
    end
  end
  always_comb begin
    ramaddr = state == GRANT ? (gdata ? daddr[gcore] : iaddr[gcore]) : '0;
    ramstore = state == GRANT && gdata ? dstore[gcore] : '0;
    ramWEN = state == GRANT && gdata && dWEN[gcore];
    ramREN = state == GRANT && (gdata ? dREN[gcore] && !dWEN[gcore] : 1'b1);
    iwait = '1;
    dwait = '1;
    iwait[gcore] = !(done && !gdata);
    dwait[gcore] = !(done && gdata);
    iload = {CPUS{ramload}};
    dload = {CPUS{ramload}};
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus, a latency-configurable RAM, and a per-cycle model check of memory_arbiter
module tb_memory_arbiter;
  import cpu_types_pkg::*;
  localparam int CPUS = 2;
  logic CLK = 1'b0;
  logic nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore, iload, dload;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int lat = 1;
  logic force_err = 1'b0;
  int comp_q[$];
  logic m_busy = 0, m_data = 0, m_core = 0, m_rr = 0;
  logic n_busy = 0, n_data = 0, n_core = 0, n_rr = 0;

  memory_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  assign ramload = 32'hDEADBEEF ^ (ramaddr - 32'h100);
  always_comb ramstate = force_err ? ERROR : !(ramREN || ramWEN) ? FREE : (cnt >= lat ? ACCESS : BUSY);
  always @(posedge CLK) cnt <= ((ramREN || ramWEN) && ramstate != ACCESS) ? cnt + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK or negedge nRST)
    if (!nRST) begin
      m_busy <= 0; m_data <= 0; m_core <= 0; m_rr <= 0;
    end else begin
      m_busy <= n_busy; m_data <= n_data; m_core <= n_core; m_rr <= n_rr;
    end

  always @(negedge CLK) begin
    logic [31:0] e_addr, e_store;
    logic e_ren, e_wen, live, fin;
    logic [1:0] e_iw, e_dw, dq;
    e_addr = 0; e_store = 0; e_ren = 0; e_wen = 0; live = 0; fin = 0;
    e_iw = 2'b11; e_dw = 2'b11;
    dq = dREN | dWEN;
    if (nRST && m_busy) begin
      if (m_data) begin
        e_addr = daddr[m_core];
        e_store = dstore[m_core];
        e_wen = dWEN[m_core];
        e_ren = dREN[m_core] && !dWEN[m_core];
        live = dq[m_core];
      end else begin
        e_addr = iaddr[m_core];
        e_ren = 1;
        live = iREN[m_core];
      end
      fin = live && ramstate == ACCESS;
      if (fin && m_data) e_dw[m_core] = 0;
      if (fin && !m_data) e_iw[m_core] = 0;
    end
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    for (int k = 0; k < CPUS; k++) begin
      chk("iload", iload[k], ramload);
      chk("dload", dload[k], ramload);
      if (!iwait[k]) comp_q.push_back(k);
      if (!dwait[k]) comp_q.push_back(10 + k);
    end
    n_busy = m_busy; n_data = m_data; n_core = m_core; n_rr = m_rr;
    if (!m_busy) begin
      if (dq != 0) begin
        n_busy = 1; n_data = 1; n_core = dq[m_rr] ? m_rr : ~m_rr;
      end else if (iREN != 0) begin
        n_busy = 1; n_data = 0; n_core = iREN[m_rr] ? m_rr : ~m_rr;
      end
    end else if (fin) begin
      n_busy = 0; n_rr = ~m_core;
    end else if (!live) n_busy = 0;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 0;
    iREN = 2'b11; dREN = 2'b11; dWEN = 0;
    iaddr[0] = 32'h400; iaddr[1] = 32'h800;
    daddr[0] = 32'h100; daddr[1] = 32'h200;
    dstore[0] = 32'h11; dstore[1] = 32'h22;
    repeat (3) step;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    nRST = 1;
    step;
    chk("first_grant_addr", ramaddr, 32'h100);
    chk("first_grant_ren", ramREN, 1);
    iREN = 0; dREN = 0;
    step;
    chk("abort_idle_ren", ramREN, 0);
    lat = 2;
    dREN[0] = 1;
    step;
    chk("rd_ren", ramREN, 1);
    chk("rd_addr", ramaddr, 32'h100);
    chk("rd_wait1", dwait[0], 1);
    step;
    chk("rd_wait2", dwait[0], 1);
    step;
    chk("rd_done", dwait[0], 0);
    chk("rd_load", dload[0], 32'hDEADBEEF);
    step;
    dREN = 0;
    step;
    lat = 0;
    iREN[0] = 1; dWEN[1] = 1; dstore[1] = 32'h55;
    step;
    chk("pri_wen", ramWEN, 1);
    chk("pri_store", ramstore, 32'h55);
    chk("pri_addr", ramaddr, 32'h200);
    chk("pri_dwait", dwait[1], 0);
    step;
    dWEN = 0;
    chk("pri_bubble_ren", ramREN, 0);
    chk("pri_bubble_iwait", iwait, 2'b11);
    step;
    chk("pri_iaddr", ramaddr, 32'h400);
    chk("pri_iwait", iwait[0], 0);
    chk("pri_iload", iload[0], 32'hDEADBDEF);
    step;
    iREN = 0;
    step;
    lat = 1;
    comp_q.delete();
    dREN = 2'b11;
    for (int k = 0; k < 40 && comp_q.size() < 4; k++) step;
    dREN = 0;
    chk("rr_count", comp_q.size(), 4);
    if (comp_q.size() >= 4) begin
      chk("rr_0", comp_q[0], 11);
      chk("rr_1", comp_q[1], 10);
      chk("rr_2", comp_q[2], 11);
      chk("rr_3", comp_q[3], 10);
    end
    step;
    lat = 2;
    comp_q.delete();
    iREN[1] = 1;
    step;
    chk("ab_ren", ramREN, 1);
    chk("ab_addr", ramaddr, 32'h800);
    chk("ab_iwait", iwait[1], 1);
    iREN = 0;
    step;
    chk("ab_idle_ren", ramREN, 0);
    chk("ab_idle_iwait", iwait, 2'b11);
    dREN = 2'b11;
    step;
    chk("ab_rr_kept", ramaddr, 32'h200);
    dREN = 0;
    step;
    step;
    chk("ab_no_completion", comp_q.size(), 0);
    lat = 0;
    force_err = 1;
    dREN[0] = 1;
    step;
    chk("err_wait1", dwait[0], 1);
    chk("err_ren1", ramREN, 1);
    step;
    chk("err_wait2", dwait[0], 1);
    step;
    chk("err_wait3", dwait[0], 1);
    step;
    force_err = 0;
    #1;
    chk("err_done", dwait[0], 0);
    step;
    dREN = 0;
    step;
    lat = 3;
    dWEN[1] = 1; dstore[1] = 32'h77;
    step;
    chk("mr_wen", ramWEN, 1);
    chk("mr_store", ramstore, 32'h77);
    nRST = 0;
    #1;
    chk("mr_wen_drop", ramWEN, 0);
    chk("mr_ren_drop", ramREN, 0);
    chk("mr_dwait", dwait, 2'b11);
    dWEN = 0;
    step;
    nRST = 1;
    dREN = 2'b11;
    step;
    chk("mr_rr_reset", ramaddr, 32'h100);
    dREN = 0;
    step;
    step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
